// File: rtl/iexecute_pipe.sv
// Registered execute stage: ALU with operand-B select, branch target, NZCV flags
// register and an iterative shift-add multiplier behind a valid/ready output register.
module iexecute_pipe #(
  parameter int WIDTH     = 64,
  parameter int BR_SHIFT  = 2,
  parameter int MUL_STEPS = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] read_data1,
  input  logic [WIDTH-1:0] read_data2,
  input  logic [WIDTH-1:0] imm,
  input  logic             alu_src,
  input  logic [3:0]       alu_ctrl,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] branch_target,
  output logic             zero,
  output logic [3:0]       nzcv,
  output logic             busy
);

  localparam int K  = WIDTH / MUL_STEPS;
  localparam int CW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_ORR   = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MUL   = 4'b1000;

  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t state;

  logic [WIDTH-1:0] op_b, res, bt;
  logic [WIDTH:0]   add_w, sub_w;
  logic             res_c, res_v;
  logic             accept;

  logic [WIDTH-1:0] mul_a, mul_b, mul_acc, mul_digit, mul_next;
  logic [CW-1:0]    mul_cnt;
  logic             mul_setf;

  // Handshake: an op enters on in_valid & in_ready; the output register is
  // consumed on out_valid & out_ready and otherwise holds every output stable.
  assign in_ready = (state == S_IDLE) && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == S_MUL);

  always_comb begin
    op_b  = alu_src ? imm : read_data2;
    add_w = {1'b0, read_data1} + {1'b0, op_b};
    sub_w = {1'b0, read_data1} + {1'b0, ~op_b} + (WIDTH+1)'(1);
    bt    = pc_in + (imm << BR_SHIFT);
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (alu_ctrl)
      OP_AND:   res = read_data1 & op_b;
      OP_ORR:   res = read_data1 | op_b;
      OP_PASSB: res = op_b;
      OP_NOR:   res = ~(read_data1 | op_b);
      OP_ADD: begin
        res   = add_w[WIDTH-1:0];
        res_c = add_w[WIDTH];
        res_v = (read_data1[WIDTH-1] == op_b[WIDTH-1]) && (res[WIDTH-1] != read_data1[WIDTH-1]);
      end
      OP_SUB: begin
        res   = sub_w[WIDTH-1:0];
        res_c = sub_w[WIDTH];
        res_v = (read_data1[WIDTH-1] != op_b[WIDTH-1]) && (res[WIDTH-1] != read_data1[WIDTH-1]);
      end
      default: res = '0;
    endcase
  end

  // Each step folds K multiplier bits into the accumulator.
  assign mul_digit = WIDTH'(mul_b[K-1:0]);
  assign mul_next  = mul_acc + mul_a * mul_digit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      out_valid     <= 1'b0;
      alu_result    <= '0;
      branch_target <= '0;
      zero          <= 1'b0;
      nzcv          <= 4'b0000;
      mul_a         <= '0;
      mul_b         <= '0;
      mul_acc       <= '0;
      mul_cnt       <= '0;
      mul_setf      <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            branch_target <= bt;
            if (alu_ctrl == OP_MUL) begin
              state    <= S_MUL;
              mul_a    <= read_data1;
              mul_b    <= op_b;
              mul_acc  <= '0;
              mul_cnt  <= '0;
              mul_setf <= set_flags;
            end else begin
              alu_result <= res;
              zero       <= (res == '0);
              out_valid  <= 1'b1;
              if (set_flags) nzcv <= {res[WIDTH-1], res == '0, res_c, res_v};
            end
          end
        end
        S_MUL: begin
          if (mul_cnt == CW'(MUL_STEPS - 1)) begin
            state      <= S_IDLE;
            alu_result <= mul_next;
            zero       <= (mul_next == '0);
            out_valid  <= 1'b1;
            if (mul_setf) nzcv <= {mul_next[WIDTH-1], mul_next == '0, 2'b00};
          end else begin
            mul_acc <= mul_next;
            mul_a   <= mul_a << K;
            mul_b   <= mul_b >> K;
            mul_cnt <= mul_cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iexecute_pipe.sv
// Directed bench for iexecute_pipe: ALU/flags vectors, handshake, multiplier
// latency, flush and asynchronous reset, with hand-computed expectations.
module tb_iexecute_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [63:0] pc_in, read_data1, read_data2, imm;
  logic        alu_src, set_flags, out_valid, out_ready, zero, busy;
  logic [3:0]  alu_ctrl, nzcv;
  logic [63:0] alu_result, branch_target;

  int errors = 0;
  int checks = 0;
  int n;

  always #5 clk = ~clk;

  iexecute_pipe #(.WIDTH(64), .BR_SHIFT(2), .MUL_STEPS(64)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .read_data1(read_data1), .read_data2(read_data2), .imm(imm),
    .alu_src(alu_src), .alu_ctrl(alu_ctrl), .set_flags(set_flags),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .branch_target(branch_target), .zero(zero), .nzcv(nzcv), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ctrl, input logic [63:0] a, input logic [63:0] b,
                       input logic src, input logic sf);
    in_valid   = 1'b1;
    alu_ctrl   = ctrl;
    read_data1 = a;
    read_data2 = b;
    alu_src    = src;
    set_flags  = sf;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pc_in = 64'h0; read_data1 = 64'h0; read_data2 = 64'h0; imm = 64'h0;
    alu_src = 1'b0; alu_ctrl = 4'b0000; set_flags = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", alu_result, 0);
    check("rst_bt", branch_target, 0);
    check("rst_nzcv", nzcv, 0);
    check("rst_zero", zero, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    step();

    // ADDS 5+7 with branch target 0x1000 + (-4<<2)
    out_ready = 1'b1;
    pc_in = 64'h1000; imm = 64'hFFFF_FFFF_FFFF_FFFC;
    drive(4'b0010, 64'd5, 64'd7, 1'b0, 1'b1);
    step();
    check("add_result", alu_result, 64'd12);
    check("add_valid", out_valid, 1);
    check("add_nzcv", nzcv, 4'b0000);
    check("add_zero", zero, 0);
    check("branch_target", branch_target, 64'h0FF0);

    // SUBS 3-3, back to back with consume
    drive(4'b0110, 64'd3, 64'd3, 1'b0, 1'b1);
    step();
    check("subs_eq_result", alu_result, 0);
    check("subs_eq_zero", zero, 1);
    check("subs_eq_nzcv", nzcv, 4'b0110);

    // SUBS signed overflow
    drive(4'b0110, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    step();
    check("subs_ovf_result", alu_result, 64'h8000_0000_0000_0000);
    check("subs_ovf_nzcv", nzcv, 4'b1001);

    // ORR with immediate operand, no flag update
    imm = 64'hF0;
    drive(4'b0001, 64'h0F, 64'h1234, 1'b1, 1'b0);
    step();
    check("orr_imm_result", alu_result, 64'hFF);
    check("orr_nzcv_hold", nzcv, 4'b1001);
    check("orr_bt", branch_target, 64'h13C0);

    // Backpressure: NOR waits while output is held
    out_ready = 1'b0;
    drive(4'b1100, 64'h0, 64'h0, 1'b0, 1'b0);
    #1;
    check("bp_in_ready", in_ready, 0);
    step();
    check("bp_hold_result", alu_result, 64'hFF);
    check("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    step();
    check("nor_result", alu_result, 64'hFFFF_FFFF_FFFF_FFFF);
    check("nor_valid", out_valid, 1);
    in_valid = 1'b0;
    step();
    check("drain_valid", out_valid, 0);

    // MUL 6*7 latency
    drive(4'b1000, 64'd6, 64'd7, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    check("mul_busy", busy, 1);
    check("mul_in_ready", in_ready, 0);
    check("mul_out_valid", out_valid, 0);
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    check("mul_latency", n, 64);
    check("mul_result", alu_result, 64'd42);
    check("mul_busy_done", busy, 0);
    check("mul_nzcv", nzcv, 4'b0000);

    // MUL wraps to zero
    drive(4'b1000, 64'h8000_0000_0000_0000, 64'd2, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    repeat (64) step();
    check("mulwrap_result", alu_result, 0);
    check("mulwrap_zero", zero, 1);
    check("mulwrap_nzcv", nzcv, 4'b0100);
    check("mulwrap_valid", out_valid, 1);
    step();

    // Flush on cycle 10 of a MUL
    drive(4'b1000, 64'd3, 64'd5, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_valid", out_valid, 0);
    check("flush_nzcv", nzcv, 4'b0100);
    repeat (70) step();
    check("flush_no_commit", out_valid, 0);

    // Flush beats in_valid
    drive(4'b0010, 64'd1, 64'd1, 1'b0, 1'b1);
    flush = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_acc_valid", out_valid, 0);
    check("flush_acc_nzcv", nzcv, 4'b0100);

    // Flush on the final MUL step
    drive(4'b1000, 64'd1, 64'd1, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    repeat (63) step();
    check("final_busy_before", busy, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("final_flush_valid", out_valid, 0);
    check("final_flush_nzcv", nzcv, 4'b0100);
    check("final_flush_busy", busy, 0);

    // SUBS 3-5 leaves nonzero state, then async reset mid-MUL
    drive(4'b0110, 64'd3, 64'd5, 1'b0, 1'b1);
    step();
    check("subs_neg_result", alu_result, 64'hFFFF_FFFF_FFFF_FFFE);
    check("subs_neg_nzcv", nzcv, 4'b1000);
    drive(4'b1000, 64'd6, 64'd7, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_busy", busy, 0);
    check("areset_valid", out_valid, 0);
    check("areset_result", alu_result, 0);
    check("areset_bt", branch_target, 0);
    check("areset_nzcv", nzcv, 0);
    step();
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
